// File: rtl/bit_unpacker.sv
// Decoder-side bit reservoir: takes packed bytes MSB-first and serves 1..MAX_REQ bit requests,
// zero-padding past end-of-stream so the arithmetic decoder can flush.
module bit_unpacker #(
    parameter int unsigned MAX_REQ = 16,
    parameter int unsigned BUF_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               stream_end,
    input  logic               req_valid,
    input  logic [4:0]         req_count,
    output logic               req_ready,
    output logic [MAX_REQ-1:0] bits_out,
    output logic               bits_valid,
    output logic [5:0]         fill_level,
    output logic               pad_active
);

    logic [BUF_W-1:0]   res_q, res_d;
    logic [5:0]         fill_q, fill_d;
    logic               eos_q, eos_d;
    logic               pad_q, pad_d;
    logic [MAX_REQ-1:0] bits_q, bits_d;
    logic               valid_q, valid_d;

    logic [5:0]         n;
    logic               req_fire;
    logic               byte_fire;
    logic [MAX_REQ-1:0] top;
    logic [BUF_W-1:0]   res_after;
    logic [5:0]         fill_after;

    always_comb begin
        n = (req_count > 5'(MAX_REQ)) ? 6'(MAX_REQ) : {1'b0, req_count};
    end

    // Gated with rst so both handshakes read 0 while reset is held.
    assign byte_ready = rst & ~eos_q & (fill_q <= 6'(BUF_W - 8));
    assign req_ready  = rst & (eos_q | (fill_q >= n));
    assign req_fire   = req_valid & req_ready;
    assign byte_fire  = byte_valid & byte_ready;

    // Bits below fill are always zero, so extraction past fill yields the padding for free.
    always_comb begin
        res_d      = res_q;
        fill_d     = fill_q;
        eos_d      = eos_q;
        pad_d      = pad_q;
        bits_d     = bits_q;
        valid_d    = 1'b0;
        top        = res_q[BUF_W-1 -: MAX_REQ];
        res_after  = res_q;
        fill_after = fill_q;

        if (req_fire) begin
            bits_d    = top >> (6'(MAX_REQ) - n);
            res_after = res_q << n;
            valid_d   = 1'b1;
            if (n > fill_q) begin
                fill_after = '0;
                pad_d      = 1'b1;
            end else begin
                fill_after = fill_q - n;
            end
        end

        // The byte lands after whatever survives this cycle's request.
        if (byte_fire) begin
            res_d  = res_after | ({byte_in, {(BUF_W - 8){1'b0}}} >> fill_after);
            fill_d = fill_after + 6'd8;
        end else begin
            res_d  = res_after;
            fill_d = fill_after;
        end

        if (stream_end) begin
            eos_d = 1'b1;
        end

        if (clr) begin
            res_d   = '0;
            fill_d  = '0;
            eos_d   = 1'b0;
            pad_d   = 1'b0;
            bits_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q   <= '0;
            fill_q  <= '0;
            eos_q   <= 1'b0;
            pad_q   <= 1'b0;
            bits_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            fill_q  <= fill_d;
            eos_q   <= eos_d;
            pad_q   <= pad_d;
            bits_q  <= bits_d;
            valid_q <= valid_d;
        end
    end

    assign bits_out   = bits_q;
    assign bits_valid = valid_q;
    assign fill_level = fill_q;
    assign pad_active = pad_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Table-driven bench for bit_unpacker; expected bit groups go through a scoreboard queue.
module tb_bit_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        stream_end;
    logic        req_valid;
    logic [4:0]  req_count;
    logic        req_ready;
    logic [15:0] bits_out;
    logic        bits_valid;
    logic [5:0]  fill_level;
    logic        pad_active;

    int errors = 0;
    int checks = 0;

    logic [15:0] sb_q[$];

    typedef struct {
        logic        clr;
        logic        bv;
        logic [7:0]  b;
        logic        se;
        logic        rv;
        logic [4:0]  rc;
        logic        exp_br;
        logic        exp_rr;
        logic [15:0] exp_bits;
        logic [5:0]  exp_fill;
        logic        exp_pad;
    } vec_t;

    vec_t vecs[$];

    bit_unpacker #(.MAX_REQ(16), .BUF_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .stream_end (stream_end),
        .req_valid  (req_valid),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .bits_out   (bits_out),
        .bits_valid (bits_valid),
        .fill_level (fill_level),
        .pad_active (pad_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every bits_valid pulse must match the oldest expected group.
    always @(negedge clk) begin
        if (bits_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected bits_valid pulse", 32'(bits_out), 32'hdead);
            end else begin
                chk("bits_out", 32'(bits_out), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic v(input logic c, input logic bv, input logic [7:0] b, input logic se,
                     input logic rv, input logic [4:0] rc, input logic ebr, input logic err,
                     input logic [15:0] ebits, input logic [5:0] efill, input logic epad);
        vec_t t;
        t.clr = c; t.bv = bv; t.b = b; t.se = se; t.rv = rv; t.rc = rc;
        t.exp_br = ebr; t.exp_rr = err; t.exp_bits = ebits; t.exp_fill = efill;
        t.exp_pad = epad;
        vecs.push_back(t);
    endtask

    // Called at a negedge; returns at the negedge after the last row's edge.
    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            clr        = vecs[i].clr;
            byte_valid = vecs[i].bv;
            byte_in    = vecs[i].b;
            stream_end = vecs[i].se;
            req_valid  = vecs[i].rv;
            req_count  = vecs[i].rc;
            #1;
            chk($sformatf("row%0d byte_ready", i), 32'(byte_ready), 32'(vecs[i].exp_br));
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rr));
            if (vecs[i].rv && vecs[i].exp_rr && !vecs[i].clr) sb_q.push_back(vecs[i].exp_bits);
            @(negedge clk);
            chk($sformatf("row%0d fill_level", i), 32'(fill_level), 32'(vecs[i].exp_fill));
            chk($sformatf("row%0d pad_active", i), 32'(pad_active), 32'(vecs[i].exp_pad));
        end
        clr = 0; byte_valid = 0; stream_end = 0; req_valid = 0; req_count = 0;
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; clr = 0; byte_in = 0; byte_valid = 0; stream_end = 0;
        req_valid = 0; req_count = 5'd8;
        #2;
        chk("reset byte_ready", 32'(byte_ready), 0);
        chk("reset req_ready", 32'(req_ready), 0);
        chk("reset fill_level", 32'(fill_level), 0);
        chk("reset bits_valid", 32'(bits_valid), 0);
        chk("reset pad_active", 32'(pad_active), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1; req_count = 0;
        #1;
        chk("post-reset byte_ready", 32'(byte_ready), 1);
        @(negedge clk);

        //   clr bv byte  se rv rc     br rr bits     fill pad
        // fill to 32, fifth byte held off
        v(0, 1, 8'hAB, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd8,  0);
        v(0, 1, 8'hCD, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd16, 0);
        v(0, 1, 8'h81, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd24, 0);
        v(0, 1, 8'h60, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd32, 0);
        v(0, 1, 8'h11, 0, 0, 5'd0,  0, 1, 16'h0000, 6'd32, 0);
        // back-to-back drain
        v(0, 0, 8'h00, 0, 1, 5'd8,  0, 1, 16'h00AB, 6'd24, 0);
        v(0, 0, 8'h00, 0, 1, 5'd16, 1, 1, 16'hCD81, 6'd8,  0);
        v(0, 0, 8'h00, 0, 1, 5'd4,  1, 1, 16'h0006, 6'd4,  0);
        v(0, 0, 8'h00, 0, 1, 5'd4,  1, 1, 16'h0000, 6'd0,  0);
        v(0, 0, 8'h00, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd0,  0);
        // request waits for data
        v(0, 1, 8'hAB, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd8,  0);
        v(0, 0, 8'h00, 0, 1, 5'd12, 1, 0, 16'h0000, 6'd8,  0);
        v(0, 1, 8'hCD, 0, 1, 5'd12, 1, 0, 16'h0000, 6'd16, 0);
        v(0, 0, 8'h00, 0, 1, 5'd12, 1, 1, 16'h0ABC, 6'd4,  0);
        // clr beats a same-cycle byte and request
        v(1, 1, 8'h55, 0, 1, 5'd4,  1, 1, 16'h0000, 6'd0,  0);
        // simultaneous consume + append
        v(0, 1, 8'hAB, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd8,  0);
        v(0, 1, 8'hEF, 0, 1, 5'd4,  1, 1, 16'h000A, 6'd12, 0);
        v(0, 0, 8'h00, 0, 1, 5'd12, 1, 1, 16'h0BEF, 6'd0,  0);
        // end of stream and zero padding
        v(0, 1, 8'h5A, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd8,  0);
        v(0, 0, 8'h00, 0, 1, 5'd4,  1, 1, 16'h0005, 6'd4,  0);
        v(0, 0, 8'h00, 1, 0, 5'd0,  1, 1, 16'h0000, 6'd4,  0);
        v(0, 0, 8'h00, 0, 1, 5'd8,  0, 1, 16'h00A0, 6'd0,  1);
        v(0, 0, 8'h00, 0, 1, 5'd16, 0, 1, 16'h0000, 6'd0,  1);
        v(0, 1, 8'h77, 0, 0, 5'd0,  0, 1, 16'h0000, 6'd0,  1);
        v(0, 0, 8'h00, 0, 1, 5'd20, 0, 1, 16'h0000, 6'd0,  1);
        // clr ends eos; byte with stream_end in same cycle still taken
        v(1, 0, 8'h00, 0, 0, 5'd0,  0, 1, 16'h0000, 6'd0,  0);
        v(0, 1, 8'h3C, 1, 0, 5'd0,  1, 1, 16'h0000, 6'd8,  0);
        v(0, 0, 8'h00, 0, 1, 5'd20, 0, 1, 16'h3C00, 6'd0,  1);
        // clamp without eos, zero-length request, build fill 20
        v(1, 0, 8'h00, 0, 0, 5'd0,  0, 1, 16'h0000, 6'd0,  0);
        v(0, 1, 8'h12, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd8,  0);
        v(0, 1, 8'h34, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd16, 0);
        v(0, 1, 8'h56, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd24, 0);
        v(0, 0, 8'h00, 0, 1, 5'd20, 1, 1, 16'h1234, 6'd8,  0);
        v(0, 0, 8'h00, 0, 1, 5'd0,  1, 1, 16'h0000, 6'd8,  0);
        v(0, 1, 8'h78, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd16, 0);
        v(0, 1, 8'h9A, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd24, 0);
        v(0, 0, 8'h00, 0, 1, 5'd4,  1, 1, 16'h0005, 6'd20, 0);
        run_table();

        // Reset mid-stream with a request about to be accepted: no pulse may follow.
        req_valid = 1; req_count = 5'd8;
        #1;
        chk("pre-reset req_ready", 32'(req_ready), 1);
        #1;
        rst = 0;
        #1;
        chk("async reset fill_level", 32'(fill_level), 0);
        chk("async reset byte_ready", 32'(byte_ready), 0);
        chk("async reset req_ready", 32'(req_ready), 0);
        chk("async reset bits_valid", 32'(bits_valid), 0);
        chk("async reset bits_out", 32'(bits_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1; req_valid = 0; req_count = 0;
        @(negedge clk);

        v(0, 1, 8'hC3, 0, 0, 5'd0,  1, 1, 16'h0000, 6'd8,  0);
        v(0, 0, 8'h00, 0, 1, 5'd3,  1, 1, 16'h0006, 6'd5,  0);
        v(0, 1, 8'hFF, 0, 1, 5'd5,  1, 1, 16'h0003, 6'd8,  0);
        v(0, 0, 8'h00, 0, 1, 5'd8,  1, 1, 16'h00FF, 6'd0,  0);
        run_table();

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
